sdram_axi_tester: RTL and testbench

AXI4 initiator that exercises the SDRAM AXI4 slave (`my_sdram_axi`) from the opposite end of the bus. On `start` it writes a deterministic address-derived pattern over a programmable region in INCR bursts. It then reads the region back, checks every beat plus the responses and IDs, and reports pass/fail and an error count. It sits beside the SDRAM controller in `top` for bring-up and regression.

---
 rtl/sdram_axi_tester.sv | 238 +++++++++++++++++++++++
 tb/tb_sdram_axi_tester.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_axi_tester.sv
// AXI4 initiator that writes an address-derived pattern over a region in INCR
// bursts, reads it back, and reports pass/fail with a saturating error count.
module sdram_axi_tester #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          BURST_LEN  = 8,
    parameter int          NUM_BURSTS = 4,
    parameter logic [31:0] PATTERN    = 32'hA5A5_5A5A,
    parameter logic [3:0]  TXN_ID     = 4'h3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [2:0]  state_dbg,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] awaddr,
    output logic [3:0]  awid,
    output logic [7:0]  awlen,
    output logic [1:0]  awburst,
    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp,
    input  logic [3:0]  bid,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic [3:0]  rid,
    input  logic        rlast
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // sender keeps valid high and its payload stable until that edge.

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_AR   = 3'd4,
        ST_R    = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    localparam logic [7:0]  LAST_K      = 8'(BURST_LEN - 1);
    localparam logic [15:0] LAST_B      = 16'(NUM_BURSTS - 1);
    localparam logic [31:0] BURST_BYTES = 32'(4 * BURST_LEN);

    state_t      state;
    state_t      state_next;
    logic [15:0] b;
    logic [7:0]  k;
    logic [31:0] burst_addr;
    logic [31:0] beat_addr;
    logic        start_ok;
    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;
    logic        ar_hs;
    logic        r_hs;
    logic        r_end;
    logic        b_last;
    logic        beat_err;
    logic [15:0] err_next;

    assign state_dbg = state;
    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign b_hs      = bvalid && bready;
    assign ar_hs     = arvalid && arready;
    assign r_hs      = rvalid && rready;
    assign b_last    = (b == LAST_B);
    // A read burst ends on rlast or on its nominal last beat, whichever comes first.
    assign r_end     = r_hs && (rlast || (k == LAST_K));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: if (start_ok) state_next = ST_AW;
            ST_AW:            if (aw_hs) state_next = ST_W;
            ST_W:             if (w_hs && wlast) state_next = ST_B;
            ST_B:             if (b_hs) state_next = b_last ? ST_AR : ST_AW;
            ST_AR:            if (ar_hs) state_next = ST_R;
            ST_R:             if (r_end) state_next = b_last ? ST_DONE : ST_AR;
            default:          state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        beat_err = 1'b0;
        if (b_hs) begin
            beat_err = (bresp != 2'b00) || (bid != TXN_ID);
        end else if (r_hs) begin
            beat_err = (rresp != 2'b00) || (rid != TXN_ID) ||
                       (rdata != (beat_addr ^ PATTERN)) || (rlast != (k == LAST_K));
        end
        err_next = err_count;
        if (beat_err && (err_count != 16'hFFFF)) err_next = err_count + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 16'd0;
            b          <= 16'd0;
            k          <= 8'd0;
            burst_addr <= 32'd0;
            beat_addr  <= 32'd0;
            awvalid    <= 1'b0;
            awaddr     <= 32'd0;
            awid       <= 4'd0;
            awlen      <= 8'd0;
            awburst    <= 2'b00;
            wvalid     <= 1'b0;
            wdata      <= 32'd0;
            wstrb      <= 4'd0;
            wlast      <= 1'b0;
            bready     <= 1'b0;
            arvalid    <= 1'b0;
            araddr     <= 32'd0;
            arid       <= 4'd0;
            arlen      <= 8'd0;
            arburst    <= 2'b00;
            rready     <= 1'b0;
        end else begin
            err_count <= err_next;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= 16'd0;
                        b          <= 16'd0;
                        burst_addr <= BASE_ADDR;
                    end
                end
                ST_AW: begin
                    if (!awvalid) begin
                        awvalid <= 1'b1;
                        awaddr  <= burst_addr;
                        awid    <= TXN_ID;
                        awlen   <= LAST_K;
                        awburst <= 2'b01;
                    end else if (awready) begin
                        awvalid   <= 1'b0;
                        wvalid    <= 1'b1;
                        wdata     <= burst_addr ^ PATTERN;
                        wstrb     <= 4'hF;
                        wlast     <= (LAST_K == 8'd0);
                        beat_addr <= burst_addr;
                        k         <= 8'd0;
                    end
                end
                ST_W: begin
                    if (w_hs) begin
                        if (wlast) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                            bready <= 1'b1;
                        end else begin
                            // Next beat is presented right away, no bubble.
                            beat_addr <= beat_addr + 32'd4;
                            k         <= k + 8'd1;
                            wdata     <= (beat_addr + 32'd4) ^ PATTERN;
                            wlast     <= ((k + 8'd1) == LAST_K);
                        end
                    end
                end
                ST_B: begin
                    if (b_hs) begin
                        bready     <= 1'b0;
                        b          <= b_last ? 16'd0 : b + 16'd1;
                        burst_addr <= b_last ? BASE_ADDR : burst_addr + BURST_BYTES;
                    end
                end
                ST_AR: begin
                    if (!arvalid) begin
                        arvalid <= 1'b1;
                        araddr  <= burst_addr;
                        arid    <= TXN_ID;
                        arlen   <= LAST_K;
                        arburst <= 2'b01;
                    end else if (arready) begin
                        arvalid   <= 1'b0;
                        rready    <= 1'b1;
                        beat_addr <= burst_addr;
                        k         <= 8'd0;
                    end
                end
                ST_R: begin
                    if (r_end) begin
                        rready     <= 1'b0;
                        b          <= b_last ? 16'd0 : b + 16'd1;
                        burst_addr <= burst_addr + BURST_BYTES;
                        if (b_last) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            pass <= (err_next == 16'd0);
                        end
                    end else if (r_hs) begin
                        beat_addr <= beat_addr + 32'd4;
                        k         <= k + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_axi_tester.sv
// Bench for sdram_axi_tester: a memory-backed AXI responder with optional stalls
// and fault injection, directed passes with hand-computed results.
module tb_sdram_axi_tester;

    localparam logic [31:0] PAT = 32'hA5A5_5A5A;
    localparam logic [3:0]  TID = 4'h3;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [2:0]  state_dbg;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;

    sdram_axi_tester #(
        .BASE_ADDR (32'h0000_1000),
        .BURST_LEN (4),
        .NUM_BURSTS(2),
        .PATTERN   (PAT),
        .TXN_ID    (TID)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
        .state_dbg(state_dbg),
        .awvalid  (awvalid),
        .awready  (awready),
        .awaddr   (awaddr),
        .awid     (awid),
        .awlen    (awlen),
        .awburst  (awburst),
        .wvalid   (wvalid),
        .wready   (wready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wlast    (wlast),
        .bvalid   (bvalid),
        .bready   (bready),
        .bresp    (bresp),
        .bid      (bid),
        .arvalid  (arvalid),
        .arready  (arready),
        .araddr   (araddr),
        .arid     (arid),
        .arlen    (arlen),
        .arburst  (arburst),
        .rvalid   (rvalid),
        .rready   (rready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rid      (rid),
        .rlast    (rlast)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Checking
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Responder state and scoreboard
    logic [31:0] mem [logic [31:0]];
    logic [31:0] aw_exp_q[$];
    logic [31:0] ar_exp_q[$];
    logic        stall_en   = 1'b0;
    logic        bad_bresp  = 1'b0;
    logic        bad_rid    = 1'b0;
    logic        flip_rdata = 1'b0;
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    int          w_k, r_k, r_len, r_burst;
    int          aw_count, ar_count;
    logic [31:0] w_base, r_base, exp_a, beat_a;
    logic        b_pend, r_act;
    logic        aw_hold, w_hold, ar_hold;
    logic [43:0] aw_saved, ar_saved;
    logic [36:0] w_saved;
    logic [31:0] first_wdata;
    logic        first_w_seen;

    function automatic int next_wait();
        return stall_en ? int'($urandom_range(5, 0)) : 0;
    endfunction

    task automatic slave_clear();
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; bresp = 2'b00; bid = 4'h0;
        rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; rid = 4'h0; rlast = 1'b0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        w_k = 0; r_k = 0; r_len = 0; r_burst = 0;
        b_pend = 1'b0; r_act = 1'b0;
        aw_hold = 1'b0; w_hold = 1'b0; ar_hold = 1'b0;
    endtask

    // Responder: drives on the falling edge, so the handshakes it sees here
    // are exactly the ones the DUT samples on the next rising edge.
    initial begin : responder
        slave_clear();
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                slave_clear();
            end else begin
                if (aw_hold) check("aw_stable", 64'({awvalid, awid, awlen, awaddr}), 64'({1'b1, aw_saved}));
                if (w_hold)  check("w_stable", 64'({wvalid, wstrb, wlast, wdata}), 64'({1'b1, w_saved}));
                if (ar_hold) check("ar_stable", 64'({arvalid, arid, arlen, araddr}), 64'({1'b1, ar_saved}));

                awready = awvalid && (aw_wait == 0);
                if (awvalid && aw_wait > 0) aw_wait--;
                wready = wvalid && (w_wait == 0);
                if (wvalid && w_wait > 0) w_wait--;
                arready = arvalid && (ar_wait == 0);
                if (arvalid && ar_wait > 0) ar_wait--;

                bvalid = b_pend && (b_wait == 0);
                if (b_pend && b_wait > 0) b_wait--;
                bresp = (bvalid && bad_bresp) ? 2'b10 : 2'b00;
                bid   = bvalid ? TID : 4'h0;

                rvalid = r_act && (r_wait == 0);
                if (r_act && r_wait > 0) r_wait--;
                if (rvalid) begin
                    beat_a = r_base + 32'(4 * r_k);
                    rdata  = mem.exists(beat_a) ? mem[beat_a] : 32'hDEAD_BEEF;
                    if (flip_rdata && r_burst == 1 && r_k == 2) rdata = rdata ^ 32'h1;
                    rresp  = 2'b00;
                    rid    = bad_rid ? 4'h0 : TID;
                    rlast  = (r_k == r_len - 1);
                end else begin
                    rdata = 32'h0; rresp = 2'b00; rid = 4'h0; rlast = 1'b0;
                end

                aw_hold  = awvalid && !awready;
                aw_saved = {awid, awlen, awaddr};
                w_hold   = wvalid && !wready;
                w_saved  = {wstrb, wlast, wdata};
                ar_hold  = arvalid && !arready;
                ar_saved = {arid, arlen, araddr};

                if (awvalid && awready) begin
                    aw_count++;
                    if (aw_exp_q.size() > 0) exp_a = aw_exp_q.pop_front();
                    else exp_a = 32'hFFFF_FFFF;
                    check("awaddr", 64'(awaddr), 64'(exp_a));
                    check("aw_attr", 64'({awid, awlen, awburst}), 64'({TID, 8'd3, 2'b01}));
                    w_base  = awaddr;
                    w_k     = 0;
                    aw_wait = next_wait();
                end
                if (wvalid && wready) begin
                    beat_a = w_base + 32'(4 * w_k);
                    check("wdata", 64'(wdata), 64'(beat_a ^ PAT));
                    check("w_attr", 64'({wstrb, wlast}), 64'({4'hF, (w_k == 3)}));
                    mem[beat_a] = wdata;
                    if (!first_w_seen) begin
                        first_w_seen = 1'b1;
                        first_wdata  = wdata;
                    end
                    w_k++;
                    w_wait = next_wait();
                    if (wlast) begin
                        b_pend = 1'b1;
                        b_wait = next_wait();
                    end
                end
                if (bvalid && bready) b_pend = 1'b0;
                if (arvalid && arready) begin
                    ar_count++;
                    if (ar_exp_q.size() > 0) exp_a = ar_exp_q.pop_front();
                    else exp_a = 32'hFFFF_FFFF;
                    check("araddr", 64'(araddr), 64'(exp_a));
                    check("ar_attr", 64'({arid, arlen, arburst}), 64'({TID, 8'd3, 2'b01}));
                    r_base  = araddr;
                    r_k     = 0;
                    r_len   = int'(arlen) + 1;
                    r_burst = ar_count - 1;
                    r_act   = 1'b1;
                    r_wait  = next_wait();
                    ar_wait = next_wait();
                end
                if (rvalid && rready) begin
                    r_k++;
                    if (r_k == r_len) r_act = 1'b0;
                    r_wait = next_wait();
                end
            end
        end
    end

    // Driver tasks
    task automatic arm_pass();
        aw_exp_q = '{};
        ar_exp_q = '{};
        aw_exp_q.push_back(32'h0000_1000);
        aw_exp_q.push_back(32'h0000_1010);
        ar_exp_q.push_back(32'h0000_1000);
        ar_exp_q.push_back(32'h0000_1010);
        aw_count     = 0;
        ar_count     = 0;
        first_w_seen = 1'b0;
        first_wdata  = 32'h0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic begin_pass(input string tag);
        arm_pass();
        pulse_start();
        check({tag, "_busy_set"}, 64'(busy), 64'(1));
        check({tag, "_done_clr"}, 64'(done), 64'(0));
    endtask

    task automatic end_pass(input string tag, input logic [15:0] exp_err, input logic exp_pass);
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 64'(done), 64'(1));
        check({tag, "_busy_clr"}, 64'(busy), 64'(0));
        check({tag, "_pass"}, 64'(pass), 64'(exp_pass));
        check({tag, "_err_count"}, 64'(err_count), 64'(exp_err));
        check({tag, "_aw_count"}, 64'(aw_count), 64'(2));
        check({tag, "_ar_count"}, 64'(ar_count), 64'(2));
        check({tag, "_first_wdata"}, 64'(first_wdata), 64'(32'hA5A5_4A5A));
        check({tag, "_addr_q_left"}, 64'(aw_exp_q.size() + ar_exp_q.size()), 64'(0));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_aw"}, 64'({awvalid, awaddr, awid, awlen, awburst}), 64'(0));
        check({tag, "_w"}, 64'({wvalid, wdata, wstrb, wlast}), 64'(0));
        check({tag, "_ar"}, 64'({arvalid, araddr, arid, arlen, arburst}), 64'(0));
        check({tag, "_misc"}, 64'({bready, rready, busy, done, pass, err_count}), 64'(0));
        check({tag, "_state"}, 64'(state_dbg), 64'(0));
    endtask

    // Directed scenarios
    initial begin : main
        int n;
        reset_n = 1'b0;
        start   = 1'b0;
        arm_pass();
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        reset_n = 1'b1;

        begin_pass("basic");
        end_pass("basic", 16'd0, 1'b1);

        stall_en = 1'b1;
        begin_pass("stall");
        end_pass("stall", 16'd0, 1'b1);
        stall_en = 1'b0;

        flip_rdata = 1'b1;
        begin_pass("rdata_flip");
        end_pass("rdata_flip", 16'd1, 1'b0);
        flip_rdata = 1'b0;

        bad_bresp = 1'b1;
        bad_rid   = 1'b1;
        begin_pass("bresp_rid");
        end_pass("bresp_rid", 16'd10, 1'b0);
        bad_bresp = 1'b0;
        bad_rid   = 1'b0;

        begin_pass("midrst");
        n = 0;
        while (state_dbg != 3'd2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reach_w", 64'(state_dbg), 64'(2));
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset("midrst");
        reset_n = 1'b1;
        begin_pass("after_rst");
        end_pass("after_rst", 16'd0, 1'b1);

        begin_pass("restart");
        repeat (3) @(posedge clk);
        #1;
        check("restart_busy_mid", 64'(busy), 64'(1));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        end_pass("restart", 16'd0, 1'b1);

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
